// File: rtl/multdiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : multdiv_seq
// Description : Control sequencer for the iterative multiply/divide unit.
//               It drives the 66-bit product/remainder register and its
//               add/sub datapath through a radix-4 Booth multiply or a
//               non-restoring divide, and reports ready/exception at the end.
// Revision    : 1.0 - initial release
// ============================================================================
module multdiv_seq #(
  parameter int MULT_CYCLES = 16,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic             clock,
  input  logic             clr,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [2:0]       booth_bits,
  input  logic             rem_sign,
  input  logic             divisor_zero,
  input  logic             sign_a,
  input  logic             sign_b,
  input  logic             mult_ovf,
  output logic             prod_en,
  output logic             prod_load,
  output logic [1:0]       alu_op,
  output logic             alu_x2,
  output logic             div_mode,
  output logic             negate_result,
  output logic             busy,
  output logic             result_rdy,
  output logic             exception,
  output logic [CNT_W-1:0] count
);

  // State encoding
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_MULT = 3'd2;
  localparam logic [2:0] S_DIV  = 3'd3;
  localparam logic [2:0] S_FIX  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  // ALU operation encoding
  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;

  // Final iteration index of each loop
  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic             is_div;      // current operation is a divide
  logic             neg_lat;     // sign_a ^ sign_b captured at divide start
  logic             zero_lat;    // divisor_zero captured at divide start
  logic             start;
  logic             div_start;

  // A start pulse always wins; simultaneous requests resolve to multiply.
  assign start     = ctrl_MULT | ctrl_DIV;
  assign div_start = ctrl_DIV & ~ctrl_MULT;

  // Next-state and counter update; a start pulse restarts from LOAD in any state.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    if (start) begin
      state_nxt = S_LOAD;
      count_nxt = '0;
    end else begin
      case (state)
        S_LOAD: begin
          count_nxt = '0;
          if (!is_div)       state_nxt = S_MULT;
          else if (zero_lat) state_nxt = S_DONE;
          else               state_nxt = S_DIV;
        end
        S_MULT: begin
          count_nxt = count + CNT_ONE;
          if (count == MULT_LAST) state_nxt = S_DONE;
        end
        S_DIV: begin
          count_nxt = count + CNT_ONE;
          if (count == DIV_LAST) state_nxt = S_FIX;
        end
        S_FIX:   state_nxt = S_DONE;
        S_DONE:  state_nxt = S_IDLE;
        S_IDLE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // State, counter and operation latches; clr aborts immediately.
  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      state    <= S_IDLE;
      count    <= '0;
      is_div   <= 1'b0;
      neg_lat  <= 1'b0;
      zero_lat <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (start) begin
        is_div   <= div_start;
        neg_lat  <= div_start & (sign_a ^ sign_b);
        zero_lat <= div_start & divisor_zero;
      end
    end
  end

  // Per-state datapath controls; everything defaults to 0 (the IDLE pattern).
  always_comb begin
    prod_en       = 1'b0;
    prod_load     = 1'b0;
    alu_op        = OP_NONE;
    alu_x2        = 1'b0;
    div_mode      = 1'b0;
    negate_result = 1'b0;
    busy          = 1'b0;
    result_rdy    = 1'b0;
    exception     = 1'b0;
    case (state)
      S_LOAD: begin
        prod_en       = 1'b1;
        prod_load     = 1'b1;
        busy          = 1'b1;
        negate_result = neg_lat;
      end
      S_MULT: begin
        prod_en = 1'b1;
        busy    = 1'b1;
        // Radix-4 Booth recoding of the current triplet
        case (booth_bits)
          3'b001, 3'b010: alu_op = OP_ADD;
          3'b011: begin
            alu_op = OP_ADD;
            alu_x2 = 1'b1;
          end
          3'b100: begin
            alu_op = OP_SUB;
            alu_x2 = 1'b1;
          end
          3'b101, 3'b110: alu_op = OP_SUB;
          default:        alu_op = OP_NONE;
        endcase
      end
      S_DIV: begin
        prod_en       = 1'b1;
        div_mode      = 1'b1;
        busy          = 1'b1;
        negate_result = neg_lat;
        // Non-restoring step: add back when the partial remainder went negative
        alu_op        = rem_sign ? OP_ADD : OP_SUB;
      end
      S_FIX: begin
        div_mode      = 1'b1;
        busy          = 1'b1;
        negate_result = neg_lat;
        // Restore a negative final remainder; otherwise leave the register alone
        if (rem_sign) begin
          prod_en = 1'b1;
          alu_op  = OP_ADD;
        end
      end
      S_DONE: begin
        result_rdy    = 1'b1;
        negate_result = neg_lat;
        exception     = is_div ? zero_lat : mult_ovf;
      end
      default: begin
        prod_en = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_multdiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_multdiv_seq
// Description : Directed, table-driven bench for the multdiv_seq sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multdiv_seq;

  logic       clock = 1'b0;
  logic       clr;
  logic       ctrl_MULT, ctrl_DIV;
  logic [2:0] booth_bits;
  logic       rem_sign, divisor_zero, sign_a, sign_b, mult_ovf;
  logic       prod_en, prod_load, alu_x2, div_mode, negate_result;
  logic       busy, result_rdy, exception;
  logic [1:0] alu_op;
  logic [5:0] count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [2:0] bits;
    logic [1:0] op;
    logic       x2;
  } booth_vec_t;

  booth_vec_t bv [8];
  int         pat [4];

  multdiv_seq #(.MULT_CYCLES(16), .DIV_CYCLES(32), .CNT_W(6)) dut (
    .clock(clock), .clr(clr), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .booth_bits(booth_bits), .rem_sign(rem_sign), .divisor_zero(divisor_zero),
    .sign_a(sign_a), .sign_b(sign_b), .mult_ovf(mult_ovf),
    .prod_en(prod_en), .prod_load(prod_load), .alu_op(alu_op), .alu_x2(alu_x2),
    .div_mode(div_mode), .negate_result(negate_result), .busy(busy),
    .result_rdy(result_rdy), .exception(exception), .count(count)
  );

  always #5 clock = ~clock;

  logic [9:0] outs;
  assign outs = {prod_en, prod_load, alu_op, alu_x2, div_mode,
                 negate_result, busy, result_rdy, exception};

  function automatic logic [9:0] pk(input logic pe, input logic pl,
                                    input logic [1:0] op, input logic x2,
                                    input logic dm, input logic ng,
                                    input logic bz, input logic rr,
                                    input logic ex);
    return {pe, pl, op, x2, dm, ng, bz, rr, ex};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc = cyc + 1;
  endtask

  // Present a start pulse for one edge; afterwards we are in cycle 1.
  task automatic issue(input logic m, input logic d, input logic dz,
                       input logic sa, input logic sb);
    ctrl_MULT = m; ctrl_DIV = d; divisor_zero = dz; sign_a = sa; sign_b = sb;
    cyc = 0;
    tick();
    ctrl_MULT = 0; ctrl_DIV = 0; divisor_zero = 0; sign_a = 0; sign_b = 0;
  endtask

  // mode 0: walk all eight Booth table rows; 1: pattern 000,101,100,111; 2: held 011
  task automatic run_mult(input int mode, input logic ovf, input logic both);
    int idx;
    issue(1'b1, both, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 19; c++) begin
      if (c > 1) tick();
      idx = (mode == 0) ? (c - 2) % 8 : (mode == 1) ? pat[(c - 2) % 4] : 3;
      if (c < 2) idx = 0;
      booth_bits = bv[idx].bits;
      mult_ovf   = ovf;
      #3;
      if (c == 1) begin
        check("mult_load", outs, pk(1, 1, 2'b00, 0, 0, 0, 1, 0, 0));
        check("mult_load_count", count, 0);
      end else if (c <= 17) begin
        check("mult_iter", outs, pk(1, 0, bv[idx].op, bv[idx].x2, 0, 0, 1, 0, 0));
        if (c == 17) check("mult_last_count", count, 15);
      end else if (c == 18) begin
        check("mult_done", outs, pk(0, 0, 2'b00, 0, 0, 0, 0, 1, ovf));
        check("mult_done_count", count, 16);
      end else begin
        check("mult_idle", outs, 10'd0);
      end
    end
    mult_ovf = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bv[0] = '{3'b000, 2'b00, 1'b0};
    bv[1] = '{3'b001, 2'b01, 1'b0};
    bv[2] = '{3'b010, 2'b01, 1'b0};
    bv[3] = '{3'b011, 2'b01, 1'b1};
    bv[4] = '{3'b100, 2'b10, 1'b1};
    bv[5] = '{3'b101, 2'b10, 1'b0};
    bv[6] = '{3'b110, 2'b10, 1'b0};
    bv[7] = '{3'b111, 2'b00, 1'b0};
    pat[0] = 0; pat[1] = 5; pat[2] = 4; pat[3] = 7;

    clr = 1; ctrl_MULT = 0; ctrl_DIV = 0; booth_bits = 0; rem_sign = 0;
    divisor_zero = 0; sign_a = 0; sign_b = 0; mult_ovf = 0;

    // Reset state
    tick(); tick();
    #3;
    check("reset_outs", outs, 10'd0);
    check("reset_count", count, 0);
    tick();
    clr = 0;

    // Multiply: Booth table, held 011, pattern with overflow, simultaneous start
    run_mult(2, 1'b0, 1'b0);
    run_mult(0, 1'b0, 1'b0);
    run_mult(1, 1'b1, 1'b0);
    run_mult(2, 1'b0, 1'b1);

    // Divide by zero: load then straight to DONE with exception
    issue(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) tick();
      #3;
      if (c == 1)      check("dz_load", outs[9:8], 2'b11);
      else if (c == 2) check("dz_done", outs, pk(0, 0, 2'b00, 0, 0, 0, 0, 1, 1));
      else             check("dz_idle", outs, 10'd0);
    end

    // Signed divide with remainder going negative from cycle 10
    issue(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 36; c++) begin
      if (c > 1) tick();
      rem_sign = (c >= 10);
      #3;
      if (c == 1)
        check("div_load", outs[9:8], 2'b11);
      else if (c <= 33) begin
        check("div_iter", outs, pk(1, 0, (c < 10) ? 2'b10 : 2'b01, 0, 1, 1, 1, 0, 0));
        if (c == 33) check("div_last_count", count, 31);
      end else if (c == 34)
        check("div_fix_restore", outs, pk(1, 0, 2'b01, 0, 1, 1, 1, 0, 0));
      else if (c == 35)
        check("div_done", outs, pk(0, 0, 2'b00, 0, 0, 1, 0, 1, 0));
      else begin
        check("div_idle", outs, 10'd0);
        check("div_idle_count", count, 32);
      end
    end
    rem_sign = 0;

    // Multiply pre-empted by a divide at cycle 6
    issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 42; c++) begin
      if (c > 1) tick();
      booth_bits = 3'b000;
      rem_sign   = 0;
      ctrl_DIV   = (c == 6);
      #3;
      check("preempt_rdy", result_rdy, (c == 41));
      if (c == 7) begin
        check("preempt_load", prod_load, 1);
        check("preempt_load_dm", div_mode, 0);
      end
      if (c == 8)  check("preempt_dm", div_mode, 1);
      if (c == 40) check("preempt_fix_hold", outs, pk(0, 0, 2'b00, 0, 1, 0, 1, 0, 0));
    end
    ctrl_DIV = 0;

    // Asynchronous clear in the middle of a divide
    issue(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) tick();
      #3;
      if (c == 20) check("abort_pre_dm", div_mode, 1);
    end
    clr = 1;
    #1;
    check("abort_outs", outs, 10'd0);
    check("abort_count", count, 0);
    tick();
    clr = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      #3;
      check("abort_no_rdy", result_rdy, 0);
    end
    run_mult(2, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
